// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and helpers for the GCD subsystem arbiter.
//   - arbState_e       : arbiter FSM state encoding (3 bits)
//   - DEFAULT_DATA_W   : default operand/result width
//   - DEFAULT_NUM_REQ  : default number of requesters
//   - MAX_REQ          : largest supported requester count
//   - rrSearch()       : pointer-rotated priority search over a request vector
package gcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_RESP  = 3'd4
    } arbState_e;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_NUM_REQ = 4;
    localparam int MAX_REQ         = 8;

    // Returns {found, index}. The search starts at ptr and wraps at numReq,
    // so the first set request at or after the pointer wins. The loop runs
    // from the far end downwards so the nearest candidate is written last.
    function automatic logic [3:0] rrSearch(input logic [MAX_REQ-1:0] req,
                                            input logic [2:0]         ptr,
                                            input logic [3:0]         numReq);
        logic [3:0] pick;
        logic [3:0] cand;
        pick = 4'd0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= numReq) begin
                cand = cand - numReq;
            end
            if ((4'(k) < numReq) && req[cand[2:0]]) begin
                pick = {1'b1, cand[2:0]};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// gcd_rr_arbiter: purely combinational round-robin search.
// Ports:
//   req_i      : per-requester request vector
//   ptr_i      : requester index where the search starts
//   grant_o    : one-hot grant
//   grantIdx_o : binary index of the granted requester
//   anyGrant_o : high when some request is set
module gcd_rr_arbiter
    import gcd_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grantIdx_o,
    output logic                       anyGrant_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [MAX_REQ-1:0] reqPad;
    logic [2:0]         ptrPad;
    logic [3:0]         pick;

    // Widen the request vector to the helper's fixed width; unused lanes stay 0.
    always_comb begin
        reqPad                = '0;
        reqPad[NUM_REQ-1:0]   = req_i;
    end

    assign ptrPad     = 3'(ptr_i);
    assign pick       = rrSearch(reqPad, ptrPad, 4'(NUM_REQ));
    assign anyGrant_o = pick[3];
    assign grantIdx_o = pick[IDX_W-1:0];

    // Decode the full picked index into the one-hot grant.
    always_comb begin
        grant_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_o[i] = pick[3] && (pick[2:0] == 3'(i));
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one GCD core among NUM_REQ requesters, round-robin.
// Each job latches operands, pulses the core reset (its finish flag is
// sticky), enables the core, waits for finish and returns the result over a
// valid/ready handshake. A zero operand bypasses the core (result = a | b).
// Ports:
//   clk_i, reset_i            : clock, asynchronous active-high reset
//   req_valid_i/req_a_i/req_b_i : per-requester request and packed operands
//   req_ready_o               : one-hot, one-cycle accept pulse
//   resp_valid_o/resp_ready_i : one-hot response handshake
//   resp_data_o, resp_err_o   : shared result bus, timeout flag
//   core_*                    : connection to the single GCD core
// Optional: define GCD_TIMEOUT_EN to add a run watchdog of TIMEOUT_CYC cycles
// that returns data 0 with resp_err_o=1; otherwise resp_err_o is tied 0.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    input  logic [NUM_REQ-1:0]        resp_ready_i,
    output logic [DATA_W-1:0]         resp_data_o,
    output logic                      resp_err_o,
    output logic                      core_nreset_o,
    output logic                      core_enable_o,
    output logic [DATA_W-1:0]         core_a_o,
    output logic [DATA_W-1:0]         core_b_o,
    input  logic                      core_finish_i,
    input  logic [DATA_W-1:0]         core_result_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arbState_e           state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    id_q, id_d;
    logic [NUM_REQ-1:0]  reqReady_q, reqReady_d;
    logic [NUM_REQ-1:0]  respValid_q, respValid_d;
    logic [DATA_W-1:0]   respData_q, respData_d;
    logic                coreNreset_q, coreNreset_d;
    logic                coreEnable_q, coreEnable_d;
    logic [DATA_W-1:0]   coreA_q, coreA_d;
    logic [DATA_W-1:0]   coreB_q, coreB_d;

`ifdef GCD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    runCnt_q, runCnt_d;
    logic                respErr_q, respErr_d;
`else
    logic                unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TIMEOUT_CYC == 0);
`endif

    logic [NUM_REQ-1:0]  grantOneHot;
    logic [IDX_W-1:0]    grantIdx;
    logic                anyGrant;
    logic [DATA_W-1:0]   selA, selB;
    logic [NUM_REQ-1:0]  idOneHot;

    gcd_rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .grant_o   (grantOneHot),
        .grantIdx_o(grantIdx),
        .anyGrant_o(anyGrant)
    );

    assign selA     = req_a_i[grantIdx*DATA_W +: DATA_W];
    assign selB     = req_b_i[grantIdx*DATA_W +: DATA_W];
    assign idOneHot = NUM_REQ'(1) << id_q;

    // Next-state and registered-output logic. Outputs are computed here for
    // the following cycle, so a grant decided in S_IDLE becomes visible as
    // the ready pulse while the FSM already sits in S_CLEAR (or S_RESP for a
    // bypass job). Bypass enters S_RESP with valid still low and raises it
    // one cycle later, which is why S_RESP sets valid when it finds it clear.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        reqReady_d   = '0;
        respValid_d  = respValid_q;
        respData_d   = respData_q;
        coreNreset_d = coreNreset_q;
        coreEnable_d = coreEnable_q;
        coreA_d      = coreA_q;
        coreB_d      = coreB_q;
`ifdef GCD_TIMEOUT_EN
        runCnt_d     = runCnt_q;
        respErr_d    = respErr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (anyGrant) begin
                    reqReady_d = grantOneHot;
                    id_d       = grantIdx;
                    coreA_d    = selA;
                    coreB_d    = selB;
`ifdef GCD_TIMEOUT_EN
                    respErr_d  = 1'b0;
`endif
                    if ((selA == '0) || (selB == '0)) begin
                        respData_d = selA | selB;
                        state_d    = S_RESP;
                    end else begin
                        state_d    = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                coreNreset_d = 1'b0;
                coreEnable_d = 1'b0;
                state_d      = S_LOAD;
            end
            S_LOAD: begin
                coreNreset_d = 1'b1;
                coreEnable_d = 1'b1;
`ifdef GCD_TIMEOUT_EN
                runCnt_d     = '0;
`endif
                state_d      = S_RUN;
            end
            S_RUN: begin
`ifdef GCD_TIMEOUT_EN
                runCnt_d = runCnt_q + CNT_W'(1);
`endif
                if (core_finish_i) begin
                    respData_d   = core_result_i;
                    coreEnable_d = 1'b0;
                    respValid_d  = idOneHot;
                    state_d      = S_RESP;
                end
`ifdef GCD_TIMEOUT_EN
                else if (runCnt_d == CNT_W'(TIMEOUT_CYC)) begin
                    respData_d   = '0;
                    respErr_d    = 1'b1;
                    coreEnable_d = 1'b0;
                    coreNreset_d = 1'b0;
                    respValid_d  = idOneHot;
                    state_d      = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (respValid_q == '0) begin
                    respValid_d = idOneHot;
                end else if (resp_ready_i[id_q]) begin
                    respValid_d = '0;
                    ptr_d       = (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + IDX_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset holds the core in reset and drops
    // any job in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            reqReady_q   <= '0;
            respValid_q  <= '0;
            respData_q   <= '0;
            coreNreset_q <= 1'b0;
            coreEnable_q <= 1'b0;
            coreA_q      <= '0;
            coreB_q      <= '0;
`ifdef GCD_TIMEOUT_EN
            runCnt_q     <= '0;
            respErr_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            reqReady_q   <= reqReady_d;
            respValid_q  <= respValid_d;
            respData_q   <= respData_d;
            coreNreset_q <= coreNreset_d;
            coreEnable_q <= coreEnable_d;
            coreA_q      <= coreA_d;
            coreB_q      <= coreB_d;
`ifdef GCD_TIMEOUT_EN
            runCnt_q     <= runCnt_d;
            respErr_q    <= respErr_d;
`endif
        end
    end

    assign req_ready_o   = reqReady_q;
    assign resp_valid_o  = respValid_q;
    assign resp_data_o   = respData_q;
    assign core_nreset_o = coreNreset_q;
    assign core_enable_o = coreEnable_q;
    assign core_a_o      = coreA_q;
    assign core_b_o      = coreB_q;
`ifdef GCD_TIMEOUT_EN
    assign resp_err_o    = respErr_q;
`else
    assign resp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: scoreboard bench for gcd_arbiter with a behavioural GCD
// core model. Grants are predicted with a plain round-robin model and the
// expected response is queued at grant time; a negedge monitor pops and
// compares on every response handshake.
module tb_gcd_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   reqValid;
    logic [N*W-1:0] reqA, reqB;
    logic [N-1:0]   req_ready_o;
    logic [N-1:0]   resp_valid_o;
    logic [N-1:0]   respReady;
    logic [W-1:0]   resp_data_o;
    logic           resp_err_o;
    logic           core_nreset_o;
    logic           core_enable_o;
    logic [W-1:0]   core_a_o, core_b_o;
    logic           coreFinish = 1'b0;
    logic [W-1:0]   coreResult = '0;

    gcd_arbiter #(
        .NUM_REQ      (N),
        .DATA_W       (W),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_valid_i  (reqValid),
        .req_a_i      (reqA),
        .req_b_i      (reqB),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (respReady),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .core_nreset_o(core_nreset_o),
        .core_enable_o(core_enable_o),
        .core_a_o     (core_a_o),
        .core_b_o     (core_b_o),
        .core_finish_i(coreFinish),
        .core_result_i(coreResult)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t         sbQ[$];
    int           checks = 0;
    int           errors = 0;
    int           modelPtr = 0;
    bit           coreHang = 1'b0;
    bit           expectTimeout = 1'b0;
    int           coreCnt = 0;
    logic [N-1:0]   validPrev = '0;
    logic [N*W-1:0] aPrev = '0, bPrev = '0;
    int           monW;
    exp_t         monE;
    logic [W-1:0] monA, monB;

    function automatic logic [W-1:0] gcdRef(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // First valid requester at or after the pointer, wrapping; -1 if none.
    function automatic int rrModel(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Behavioural core: cleared by its reset, finishes a random number of
    // enabled cycles later and keeps finish high until reset again.
    always @(posedge clk) begin
        if (!core_nreset_o) begin
            coreFinish <= 1'b0;
            coreCnt    <= $urandom_range(0, 6);
        end else if (core_enable_o && !coreFinish && !coreHang) begin
            if (coreCnt == 0) begin
                coreFinish <= 1'b1;
                coreResult <= gcdRef(core_a_o, core_b_o);
            end else begin
                coreCnt <= coreCnt - 1;
            end
        end
    end

    // Monitor: predicts each grant, queues its expected result, and checks
    // every response handshake against the head of the queue.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (req_ready_o != '0) begin
                monW = rrModel(validPrev, modelPtr);
                checkOutput("grant_onehot", req_ready_o, (monW < 0) ? 0 : (1 << monW));
                checkOutput("grant_while_busy", sbQ.size(), 0);
                if (monW >= 0) begin
                    monA = aPrev[monW*W +: W];
                    monB = bPrev[monW*W +: W];
                    monE.id = monW;
                    if (expectTimeout && monA != 0 && monB != 0) begin
                        monE.data = '0;
                        monE.err  = 1'b1;
                    end else begin
                        monE.data = gcdRef(monA, monB);
                        monE.err  = 1'b0;
                    end
                    sbQ.push_back(monE);
                end
            end
            if ((resp_valid_o & respReady) != '0) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: got valid %b expected none", resp_valid_o);
                end else begin
                    monE = sbQ.pop_front();
                    checkOutput("resp_port", resp_valid_o, 1 << monE.id);
                    checkOutput("resp_data", resp_data_o, monE.data);
                    checkOutput("resp_err", resp_err_o, monE.err);
                    modelPtr = (monE.id + 1) % N;
                end
            end
        end
        validPrev = reqValid;
        aPrev     = reqA;
        bPrev     = reqB;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        reqValid = reqValid & ~req_ready_o;
    endtask

    task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        reqA[id*W +: W] = a;
        reqB[id*W +: W] = b;
        reqValid[id]    = 1'b1;
    endtask

    task automatic waitGrant(input int id, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (req_ready_o[id]) seen = 1'b1;
        end
        checkOutput("grant_seen", seen, 1);
    endtask

    task automatic waitRespValid(input int id, input int budget, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            cycles++;
            if (resp_valid_o[id]) seen = 1'b1;
        end
        checkOutput("resp_valid_seen", seen, 1);
    endtask

    task automatic waitDrain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (reqValid == '0 && req_ready_o == '0 && sbQ.size() == 0 && resp_valid_o == '0)
                done = 1'b1;
        end
        checkOutput("drain_done", done, 1);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_req_ready", req_ready_o, 0);
        checkOutput("rst_resp_valid", resp_valid_o, 0);
        checkOutput("rst_resp_data", resp_data_o, 0);
        checkOutput("rst_resp_err", resp_err_o, 0);
        checkOutput("rst_core_nreset", core_nreset_o, 0);
        checkOutput("rst_core_enable", core_enable_o, 0);
        checkOutput("rst_core_a", core_a_o, 0);
        checkOutput("rst_core_b", core_b_o, 0);
    endtask

    task automatic resetDut();
        reset_i       = 1'b1;
        reqValid      = '0;
        coreHang      = 1'b0;
        expectTimeout = 1'b0;
        sbQ.delete();
        modelPtr      = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset_i   = 1'b1;
        reqValid  = '0;
        reqA      = '0;
        reqB      = '0;
        respReady = '1;
        #2;
        checkResetOutputs();
        resetDut();

        // Single job with clear/load timing.
        applyStimulus(0, 16'd48, 16'd18);
        waitGrant(0, 20);
        tick();
        checkOutput("clear_nreset_low", core_nreset_o, 0);
        checkOutput("ready_single_pulse", req_ready_o, 0);
        tick();
        checkOutput("load_nreset_high", core_nreset_o, 1);
        checkOutput("load_enable", core_enable_o, 1);
        waitDrain(100);

        // Four simultaneous requests from a fresh pointer.
        resetDut();
        applyStimulus(0, 16'd12, 16'd8);
        applyStimulus(1, 16'd35, 16'd14);
        applyStimulus(2, 16'd9, 16'd6);
        applyStimulus(3, 16'd100, 16'd75);
        waitDrain(400);

        // After requester 2, requester 3 outranks requester 1.
        applyStimulus(2, 16'd27, 16'd36);
        waitDrain(100);
        applyStimulus(1, 16'd50, 16'd20);
        applyStimulus(3, 16'd81, 16'd54);
        waitGrant(3, 20);
        checkOutput("req1_still_waiting", reqValid[1], 1);
        waitDrain(200);

        // Zero-operand bypass.
        applyStimulus(1, 16'd0, 16'd21);
        waitGrant(1, 20);
        tick();
        checkOutput("bypass_valid", resp_valid_o, 4'b0010);
        checkOutput("bypass_data", resp_data_o, 21);
        checkOutput("bypass_no_enable", core_enable_o, 0);
        waitDrain(50);
        applyStimulus(1, 16'd0, 16'd0);
        waitDrain(50);

        // Response stall; other ports' ready must be ignored.
        respReady = 4'b1011;
        applyStimulus(2, 16'd84, 16'd36);
        waitGrant(2, 20);
        applyStimulus(3, 16'd10, 16'd4);
        waitRespValid(2, 50, n);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_valid", resp_valid_o, 4'b0100);
            checkOutput("stall_data", resp_data_o, 12);
            checkOutput("stall_no_grant", req_ready_o, 0);
        end
        respReady = '1;
        waitDrain(200);

        // Reset while the core runs.
        coreHang = 1'b1;
        applyStimulus(0, 16'd30, 16'd45);
        waitGrant(0, 20);
        repeat (3) tick();
        checkOutput("run_enable_before_reset", core_enable_o, 1);
        reset_i = 1'b1;
        #1;
        checkResetOutputs();
        resetDut();
        applyStimulus(0, 16'd30, 16'd45);
        waitDrain(100);

`ifdef GCD_TIMEOUT_EN
        // Watchdog: a hung core produces an error response.
        coreHang      = 1'b1;
        expectTimeout = 1'b1;
        applyStimulus(1, 16'd40, 16'd24);
        waitGrant(1, 20);
        waitRespValid(1, 100, n);
        checkOutput("timeout_latency", n, TO + 2);
        checkOutput("timeout_core_reset", core_nreset_o, 0);
        waitDrain(50);
        coreHang      = 1'b0;
        expectTimeout = 1'b0;
        applyStimulus(2, 16'd40, 16'd24);
        waitDrain(100);
`endif

        // Randomised traffic with random response back-pressure.
        for (int c = 0; c < 600; c++) begin
            tick();
            respReady = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!reqValid[i] && $urandom_range(0, 3) == 0) begin
                    logic [W-1:0] f, ra, rb;
                    f  = W'($urandom_range(1, 40));
                    ra = ($urandom_range(0, 9) == 0) ? '0 : f * W'($urandom_range(1, 60));
                    rb = ($urandom_range(0, 9) == 0) ? '0 : f * W'($urandom_range(1, 60));
                    applyStimulus(i, ra, rb);
                end
            end
        end
        respReady = '1;
        waitDrain(2000);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
